// File: rtl/bin2sseg_if.sv
// Bus between the binary-to-seven-segment encoder and its user: conversion
// request with operands on one side, ready/done and four digit patterns on the other.
interface bin2sseg_if;
    logic        start;
    logic [13:0] bin;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        ready;
    logic        done_tick;
    logic [7:0]  sseg3;
    logic [7:0]  sseg2;
    logic [7:0]  sseg1;
    logic [7:0]  sseg0;

    modport master (
        output start, bin, dp_in, blank_lz,
        input  ready, done_tick, sseg3, sseg2, sseg1, sseg0
    );

    modport slave (
        input  start, bin, dp_in, blank_lz,
        output ready, done_tick, sseg3, sseg2, sseg1, sseg0
    );
endinterface

// File: rtl/bin2sseg.sv
// Iterative 14-bit binary to four-digit BCD (double dabble) converter with
// active-low seven-segment encoding, leading-zero blanking and decimal points.
module bin2sseg (
    input  logic       clk,
    input  logic       reset,
    bin2sseg_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        ENC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] bcd_q, bcd_d;
    logic [13:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  dp_q, dp_d;
    logic        blz_q, blz_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic [7:0]  sseg_q [4];
    logic [7:0]  sseg_d [4];

    logic [15:0] bcd_adj;
    logic [3:0]  digit   [4];
    logic [3:0]  blank;
    logic [7:0]  pattern [4];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Blanking cascades from the leftmost digit; digit 0 always shows.
    assign blank[3] = blz_q && (digit[3] == 4'd0);
    assign blank[2] = blank[3] && (digit[2] == 4'd0);
    assign blank[1] = blank[2] && (digit[1] == 4'd0);
    assign blank[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit[gi] = bcd_q[gi*4 +: 4];
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 :
                                        bcd_q[gi*4 +: 4];
            // Overflow shows a dash with the point forced off.
            assign pattern[gi] = ovf_q ? 8'hFE :
                                 {~dp_q[gi], blank[gi] ? 7'h7F : seg7(digit[gi])};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dp_d    = dp_q;
        blz_d   = blz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        sseg_d  = sseg_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bcd_d   = 16'd0;
                    shift_d = bus.bin;
                    cnt_d   = 4'd14;
                    dp_d    = bus.dp_in;
                    blz_d   = bus.blank_lz;
                    ovf_d   = (bus.bin > 14'd9999);
                    state_d = OP;
                end
            end
            OP: begin
                {bcd_d, shift_d} = {bcd_adj[14:0], shift_q, 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ENC;
                end
            end
            ENC: begin
                sseg_d  = pattern;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bcd_q   <= 16'd0;
            shift_q <= 14'd0;
            cnt_q   <= 4'd0;
            dp_q    <= 4'd0;
            blz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            sseg_q  <= '{default: 8'hFF};
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            blz_q   <= blz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            sseg_q  <= sseg_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.done_tick = done_q;
    assign bus.sseg3     = sseg_q[3];
    assign bus.sseg2     = sseg_q[2];
    assign bus.sseg1     = sseg_q[1];
    assign bus.sseg0     = sseg_q[0];
endmodule

// File: tb/tb_bin2sseg.sv
// Directed self-checking bench for bin2sseg: reset, encodings, blanking,
// overflow, ignored starts, back-to-back throughput and mid-conversion reset.
module tb_bin2sseg;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bin2sseg_if bus ();

    bin2sseg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] segs();
        return {bus.sseg3, bus.sseg2, bus.sseg1, bus.sseg0};
    endfunction

    // Caller is positioned just after a rising edge; returns cycles from the
    // accepting edge to the edge that raised done_tick, or -1 on timeout.
    task automatic run_conv(input logic [13:0] b, input logic [3:0] dp,
                            input logic blz, output int lat);
        bus.bin      = b;
        bus.dp_in    = dp;
        bus.blank_lz = blz;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.done_tick) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.bin      = 14'd0;
        bus.dp_in    = 4'd0;
        bus.blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (segs() !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_sseg got=%h want=%h", segs(), 32'hFFFF_FFFF);
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b want=1", bus.ready);
        end
        checks++;
        if (bus.done_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b want=0", bus.done_tick);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_nostart ready got=%b want=1", bus.ready);
        end
        $display("test_reset: sseg=%h ready=%b", segs(), bus.ready);
    endtask

    task automatic test_vec(input string name, input logic [13:0] b,
                            input logic [3:0] dp, input logic blz,
                            input logic [31:0] exp);
        int lat;
        run_conv(b, dp, blz, lat);
        checks++;
        if (lat !== 15) begin
            errors++;
            $display("FAIL %s_latency got=%0d want=15", name, lat);
        end
        checks++;
        if (segs() !== exp) begin
            errors++;
            $display("FAIL %s_sseg got=%h want=%h", name, segs(), exp);
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got=%b want=1", name, bus.ready);
        end
        $display("%s: bin=%0d dp=%b blz=%b lat=%0d sseg=%h", name, b, dp, blz, lat, segs());
    endtask

    task automatic test_ignore_start();
        int lat;
        bus.bin = 14'd1234; bus.dp_in = 4'd0; bus.blank_lz = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            bus.start = (i == 3 || i == 7 || i == 10);
            if (i == 3) begin
                bus.bin = 14'd9999; bus.dp_in = 4'hF; bus.blank_lz = 1'b1;
            end
            if (i > 10) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done_tick) begin
                lat = i;
                break;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (lat !== 15) begin
            errors++;
            $display("FAIL ignore_latency got=%0d want=15", lat);
        end
        checks++;
        if (segs() !== 32'hCF92_86CC) begin
            errors++;
            $display("FAIL ignore_sseg got=%h want=%h", segs(), 32'hCF92_86CC);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_idle ready got=%b want=1", bus.ready);
        end
        $display("test_ignore_start: lat=%0d sseg=%h", lat, segs());
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [31:0] s1;
        t1 = -1; t2 = -1; s1 = '0;
        bus.bin = 14'd1234; bus.dp_in = 4'd0; bus.blank_lz = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus.done_tick) begin
                if (t1 < 0) begin
                    t1 = i;
                    s1 = segs();
                    bus.bin = 14'd9999;
                end else begin
                    t2 = i;
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (t1 !== 15) begin
            errors++;
            $display("FAIL b2b_first got=%0d want=15", t1);
        end
        checks++;
        if (t2 - t1 !== 16) begin
            errors++;
            $display("FAIL b2b_period got=%0d want=16", t2 - t1);
        end
        checks++;
        if (s1 !== 32'hCF92_86CC) begin
            errors++;
            $display("FAIL b2b_sseg1 got=%h want=%h", s1, 32'hCF92_86CC);
        end
        checks++;
        if (segs() !== 32'h8484_8484) begin
            errors++;
            $display("FAIL b2b_sseg2 got=%h want=%h", segs(), 32'h8484_8484);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stop ready got=%b want=1", bus.ready);
        end
        $display("test_back_to_back: t1=%0d t2=%0d sseg=%h", t1, t2, segs());
    endtask

    task automatic test_reset_mid();
        int dones;
        bus.bin = 14'd1234; bus.dp_in = 4'd0; bus.blank_lz = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy ready got=%b want=0", bus.ready);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.done_tick !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state ready=%b done=%b want ready=1 done=0", bus.ready, bus.done_tick);
        end
        checks++;
        if (segs() !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL midrst_sseg got=%h want=%h", segs(), 32'hFFFF_FFFF);
        end
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done_tick) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midrst_nodone got=%0d want=0", dones);
        end
        $display("test_reset_mid: sseg=%h dones=%0d", segs(), dones);
        test_vec("after_reset_42", 14'd42, 4'd0, 1'b1, 32'hFFFF_CC92);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.bin = '0;
        bus.dp_in = '0;
        bus.blank_lz = 1'b0;
        #1;
        test_reset();
        test_vec("v1234",      14'd1234,  4'b0000, 1'b0, 32'hCF92_86CC);
        test_vec("v5_noblank", 14'd5,     4'b0100, 1'b0, 32'h8101_81A4);
        test_vec("v5_blank",   14'd5,     4'b0100, 1'b1, 32'hFF7F_FFA4);
        test_vec("v0_blank",   14'd0,     4'b0000, 1'b1, 32'hFFFF_FF81);
        test_vec("v9999",      14'd9999,  4'b0000, 1'b0, 32'h8484_8484);
        test_vec("v10000",     14'd10000, 4'hF,    1'b1, 32'hFEFE_FEFE);
        test_vec("v16383",     14'd16383, 4'hF,    1'b0, 32'hFEFE_FEFE);
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bin2sseg.md
# bin2sseg

Iterative binary-to-decimal display encoder feeding the four-digit seven-segment multiplexer. It accepts a 14-bit binary value on a start pulse and converts it to four BCD digits by shift-and-add-3 (double dabble). It then encodes each digit to an active-low 8-bit segment pattern, with optional leading-zero blanking and per-digit decimal points. Its four registered pattern outputs connect directly to the multiplexer's digit inputs (digit 3 leftmost).

## Interface
- No parameters; widths fixed (14-bit input covers 0–9999 plus overflow detection).
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  request conversion; sampled only when ready=1
- bin  input  14  unsigned value to display; latched on accepted start
- dp_in  input  4  decimal-point enables, bit i → digit i, active-high; latched on accepted start
- blank_lz  input  1  leading-zero blanking enable; latched on accepted start
- ready  output  1  high iff FSM in IDLE (combinational from state)
- done_tick  output  1  one-cycle pulse when new patterns are valid
- sseg3, sseg2, sseg1, sseg0  output  8 each  segment patterns, registered; bit7=dp, bits6..0 = a,b,c,d,e,f,g (a at bit6); all active-low

## Operation
- States: IDLE, OP, ENC.
- IDLE: ready=1. On start=1, latch bin, dp_in, blank_lz; set ovf = (bin > 9999); clear BCD register (16 bits) and load shift register with bin; load iteration counter with 14; go to OP.
- OP: each cycle, for each BCD nibble ≥5 add 3, then shift {bcd, bin_shift} left by one; decrement counter. After the 14th shift go to ENC. The adjust and shift happen in the same cycle (adjust on current nibbles, then shift the adjusted result).
- ENC: compute and register all four sseg outputs; assert done_tick; go to IDLE.
- Digit encoding (bits6..0): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Blank pattern bits6..0 = 1111111; dash = 1111110 (g only).
- Leading-zero blanking (blank_lz=1): digit3 is blanked if zero; digit2 if it and digit3 are zero; digit1 if it and digits 3..2 are zero. Digit0 is never blanked.
- dp: bit7 = ~dp_q[i], independent of blanking.
- Overflow (ovf=1): all four digits show a dash and bit7=1 (dp forced off), regardless of dp_in and blank_lz.
- sseg outputs hold their value between conversions; they change only in ENC or on reset.

## Timing
- Reset values: state IDLE, ready=1, done_tick=0, sseg3..sseg0 = 8'hFF (fully blank), internal registers 0.
- Latency: start accepted at edge E0; OP occupies edges E1..E14; ENC at E15 updates sseg outputs and asserts done_tick for the cycle after E15; ready=1 again in that same cycle.
- A start held high in the done_tick cycle begins the next conversion immediately (throughput 16 cycles).
- start while ready=0 is ignored; bin, dp_in, and blank_lz may change freely during conversion.
- Reset asserted mid-conversion: the next edge forces IDLE, blanks outputs, and emits no done_tick.
- Reset and start in the same cycle: reset wins.

## Test plan
- Reset: hold reset for 2 cycles → sseg3..0 = FF, ready=1, done_tick=0. Pulse start with bin=0 during reset → no conversion.
- bin=1234, blank_lz=0, dp_in=0 → done_tick exactly 15 cycles after the accepting edge; sseg3..0 = CF, 92, 86, CC.
- bin=5, blank_lz=0, dp_in=4'b0100 → 81, 01, 81, A4. Same with blank_lz=1 → FF, 7F, FF, A4.
- bin=0 with blank_lz=1 → FF, FF, FF, 81. bin=9999 → 84 on all digits. bin=10000 or bin=16383 → FE on all digits, even with dp_in=4'hF.
- Start pulses during OP → ignored; the result reflects the first value only. Back-to-back start held high → done_tick every 16 cycles.
- Reset asserted at OP cycle 7 → IDLE next cycle, outputs FF, no done_tick; a following conversion of 42 (blank_lz=1) gives FF, FF, CC, 92.
